// File: rtl/phys_reg_free_list.sv
// Rename free list of physical tags with single-cycle flush rewind; optional checker under FREELIST_CHECK_EN.
// Zero latency: show-ahead tag and busy-set share the consuming edge; Alloc_IN while empty or flushing is dropped.
module phys_reg_free_list #(
  parameter int NUM_PHYS_REGS = 64,
  parameter int NUM_ARCH_REGS = 32,
  localparam int LOG_PHYS = $clog2(NUM_PHYS_REGS),
  localparam int DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                Alloc_IN,
  output logic                AllocReady_OUT,
  output logic [LOG_PHYS-1:0] AllocTag_OUT,
  input  logic                Commit_IN,
  input  logic [LOG_PHYS-1:0] FreeTag_IN,
  input  logic                Flush_IN,
  output logic [LOG_PHYS:0]   FreeCount_OUT,
  output logic [LOG_PHYS-1:0] BusyReg_OUT,
  output logic                SetBusy_OUT,
  output logic                BusyValue_OUT,
  output logic                Error_OUT
);

  logic [LOG_PHYS-1:0] mem [DEPTH];
  logic [PTR_W-1:0]    specHead;
  logic [PTR_W-1:0]    commitHead;
  logic [PTR_W-1:0]    tail;
  logic [LOG_PHYS:0]   freeCnt;
  logic                fire;
  logic [PTR_W-1:0]    commitHeadNext;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign AllocReady_OUT = (freeCnt != '0);
  assign AllocTag_OUT   = mem[specHead];
  assign fire           = Alloc_IN & AllocReady_OUT & ~Flush_IN;
  assign SetBusy_OUT    = fire;
  assign BusyReg_OUT    = AllocTag_OUT;
  assign BusyValue_OUT  = 1'b1;
  assign FreeCount_OUT  = freeCnt;

  // Flush rewinds to the commit point as it stands after this cycle's commit.
  assign commitHeadNext = Commit_IN ? nextPtr(commitHead) : commitHead;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= LOG_PHYS'(NUM_ARCH_REGS + i);
      end
      specHead   <= '0;
      commitHead <= '0;
      tail       <= '0;
      freeCnt    <= (LOG_PHYS+1)'(DEPTH);
    end else begin
      if (Commit_IN) begin
        mem[tail]  <= FreeTag_IN;
        tail       <= nextPtr(tail);
        commitHead <= commitHeadNext;
      end
      if (Flush_IN) begin
        specHead <= commitHeadNext;
        freeCnt  <= (LOG_PHYS+1)'(DEPTH);
      end else begin
        if (fire) begin
          specHead <= nextPtr(specHead);
        end
        case ({fire, Commit_IN})
          2'b10:   freeCnt <= freeCnt - 1'b1;
          2'b01:   freeCnt <= freeCnt + 1'b1;
          default: freeCnt <= freeCnt;
        endcase
      end
    end
  end

`ifdef FREELIST_CHECK_EN
  logic errReg;

  // Sticky: a commit with nothing outstanding or an out-of-range tag.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      errReg <= 1'b0;
    end else if (Commit_IN &&
                 ((freeCnt == (LOG_PHYS+1)'(DEPTH)) ||
                  ({1'b0, FreeTag_IN} >= (LOG_PHYS+1)'(NUM_PHYS_REGS)))) begin
      errReg <= 1'b1;
    end
  end

  assign Error_OUT = errReg;
`else
  assign Error_OUT = 1'b0;
`endif

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed bench for phys_reg_free_list: stimulus queues expected busy-port tags, a monitor pops and compares them.
module tb_phys_reg_free_list;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       Alloc_IN = 1'b0;
  logic       AllocReady_OUT;
  logic [5:0] AllocTag_OUT;
  logic       Commit_IN = 1'b0;
  logic [5:0] FreeTag_IN = '0;
  logic       Flush_IN = 1'b0;
  logic [6:0] FreeCount_OUT;
  logic [5:0] BusyReg_OUT;
  logic       SetBusy_OUT;
  logic       BusyValue_OUT;
  logic       Error_OUT;

  int passCnt = 0;
  int totalCnt = 0;
  int tagQ[$];
  int expErr;

  phys_reg_free_list dut (
    .CLK(CLK), .RESET(RESET),
    .Alloc_IN(Alloc_IN), .AllocReady_OUT(AllocReady_OUT), .AllocTag_OUT(AllocTag_OUT),
    .Commit_IN(Commit_IN), .FreeTag_IN(FreeTag_IN), .Flush_IN(Flush_IN),
    .FreeCount_OUT(FreeCount_OUT), .BusyReg_OUT(BusyReg_OUT), .SetBusy_OUT(SetBusy_OUT),
    .BusyValue_OUT(BusyValue_OUT), .Error_OUT(Error_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    totalCnt++;
    if (act == exp) passCnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Monitor: every busy-port write must match the next queued tag.
  always @(negedge CLK) begin
    if (!RESET && SetBusy_OUT) begin
      if (tagQ.size() == 0) begin
        chk("unexpected_setbusy_tag", int'(BusyReg_OUT), -1);
      end else begin
        chk("busy_tag", int'(BusyReg_OUT), tagQ.pop_front());
        chk("busy_value", int'(BusyValue_OUT), 1);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic a, input logic c, input int t, input logic f);
    Alloc_IN   = a;
    Commit_IN  = c;
    FreeTag_IN = 6'(t);
    Flush_IN   = f;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic allocStep(input int expTag);
    drive(1'b1, 1'b0, 0, 1'b0);
    tagQ.push_back(expTag);
    step();
    idle();
  endtask

  task automatic doReset();
    idle();
    RESET = 1'b1;
    step();
    step();
    RESET = 1'b0;
  endtask

  initial begin
`ifdef FREELIST_CHECK_EN
    expErr = 1;
`else
    expErr = 0;
`endif
    step();

    // 1: reset then idle
    doReset();
    step();
    chk("reset_ready", int'(AllocReady_OUT), 1);
    chk("reset_tag", int'(AllocTag_OUT), 32);
    chk("reset_count", int'(FreeCount_OUT), 32);
    chk("reset_setbusy", int'(SetBusy_OUT), 0);
    chk("reset_error", int'(Error_OUT), 0);

    // 2: drain the list, then request while empty
    for (int i = 0; i < 32; i++) allocStep(32 + i);
    drive(1'b1, 1'b0, 0, 1'b0);
    #1;
    chk("empty_ready", int'(AllocReady_OUT), 0);
    chk("empty_setbusy", int'(SetBusy_OUT), 0);
    chk("empty_count", int'(FreeCount_OUT), 0);
    step();
    idle();
    chk("empty_count_after", int'(FreeCount_OUT), 0);

    // 3: commit returns tag 5 behind the remaining free tags
    doReset();
    for (int i = 0; i < 3; i++) allocStep(32 + i);
    chk("t3_count_before", int'(FreeCount_OUT), 29);
    drive(1'b0, 1'b1, 5, 1'b0);
    step();
    idle();
    chk("t3_count_after", int'(FreeCount_OUT), 30);
    for (int i = 35; i < 64; i++) allocStep(i);
    chk("t3_next_tag", int'(AllocTag_OUT), 5);
    chk("t3_count_one", int'(FreeCount_OUT), 1);
    allocStep(5);
    chk("t3_ready_empty", int'(AllocReady_OUT), 0);

    // 4: commit then flush rewinds speculative head
    doReset();
    for (int i = 0; i < 4; i++) allocStep(32 + i);
    drive(1'b0, 1'b1, 7, 1'b0);
    step();
    chk("t4_count_commit", int'(FreeCount_OUT), 29);
    drive(1'b0, 1'b0, 0, 1'b1);
    step();
    idle();
    chk("t4_count_flush", int'(FreeCount_OUT), 32);
    chk("t4_tag_flush", int'(AllocTag_OUT), 33);
    for (int i = 33; i < 64; i++) allocStep(i);
    chk("t4_tag_wrap", int'(AllocTag_OUT), 7);
    allocStep(7);
    chk("t4_count_end", int'(FreeCount_OUT), 0);

    // 5: alloc + commit + flush together: alloc suppressed
    doReset();
    allocStep(32);
    allocStep(33);
    drive(1'b1, 1'b1, 9, 1'b1);
    #1;
    chk("t5_setbusy", int'(SetBusy_OUT), 0);
    step();
    idle();
    chk("t5_tag", int'(AllocTag_OUT), 33);
    chk("t5_count", int'(FreeCount_OUT), 32);

    // alloc + commit in one cycle keeps the count
    doReset();
    allocStep(32);
    drive(1'b1, 1'b1, 10, 1'b0);
    tagQ.push_back(33);
    step();
    idle();
    chk("ac_count", int'(FreeCount_OUT), 31);
    chk("ac_tag", int'(AllocTag_OUT), 34);

    // 6: commit with nothing outstanding
    doReset();
    drive(1'b0, 1'b1, 3, 1'b0);
    step();
    idle();
    chk("t6_error_set", int'(Error_OUT), expErr);
    step();
    step();
    step();
    chk("t6_error_sticky", int'(Error_OUT), expErr);
    doReset();
    chk("t6_error_cleared", int'(Error_OUT), 0);

    step();
    chk("queue_drained", tagQ.size(), 0);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
